// File: rtl/mem_resp_pkg.sv
// ============================================================================
// Module      : mem_resp_pkg
// Description : Shared state encoding and parameter defaults for mem_responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_resp_pkg;

    localparam int C_DEPTH_WORDS_DEFAULT = 256;
    localparam int C_WAIT_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_resp_array.sv
// ============================================================================
// Module      : mem_resp_array
// Description : Word storage, one write port, one async read port, async clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_resp_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // One flop bank per word so the whole array clears in the reset branch.
    for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_word
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_mem[i] <= '0;
            end else if (i_we && (i_waddr == ADDR_W'(i))) begin
                r_mem[i] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding memory responder with fixed wait states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = C_DEPTH_WORDS_DEFAULT,
    parameter int WAIT_CYCLES = C_WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_WAIT   = 4'(WAIT_CYCLES);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_rsp_err;
    logic [31:0]         r_rsp_rdata;

    logic                w_idle;
    logic                w_accept;
    logic                w_enter_resp;
    logic                w_acc_we;
    logic [31:0]         w_acc_addr;
    logic [31:0]         w_acc_wdata;
    logic [31:0]         w_word;
    logic                w_err;
    logic [c_ADDR_W-1:0] w_idx;
    logic                w_mem_we;
    logic [31:0]         w_mem_rdata;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && req_valid;

    // With zero wait states the access happens on the accept edge itself,
    // before the latched copies are valid, so take the live request then.
    assign w_acc_we    = w_idle ? req_we    : r_we;
    assign w_acc_addr  = w_idle ? req_addr  : r_addr;
    assign w_acc_wdata = w_idle ? req_wdata : r_wdata;

    assign w_enter_resp = (w_accept && (c_WAIT == 4'd0)) ||
                          ((r_state == WAIT) && (r_cnt == 4'd1));

    assign w_word   = {2'b00, w_acc_addr[31:2]};
    assign w_err    = (w_acc_addr[1:0] != 2'b00) || (w_word >= 32'(DEPTH_WORDS));
    assign w_idx    = w_word[c_ADDR_W-1:0];
    assign w_mem_we = w_enter_resp && w_acc_we && !w_err;

    mem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_mem_we),
        .i_waddr (w_idx),
        .i_wdata (w_acc_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (c_WAIT == 4'd0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase

            if (w_enter_resp) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || w_acc_we) ? 32'd0 : w_mem_rdata;
            end
        end
    end

    assign req_ready = w_idle;
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench; two responders (2 and 0 wait states).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

    localparam int c_DEPTH0 = 256;
    localparam int c_WAIT0  = 2;
    localparam int c_DEPTH1 = 16;
    localparam int c_WAIT1  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv  [2];
    logic        rwe [2];
    logic        rr  [2];
    logic [31:0] ra  [2];
    logic [31:0] rwd [2];
    logic        qrdy[2];
    logic        qval[2];
    logic        qerr[2];
    logic [31:0] qdat[2];

    int          checks   = 0;
    int          failures = 0;
    int          depth[2] = '{c_DEPTH0, c_DEPTH1};
    int          waitc[2] = '{c_WAIT0, c_WAIT1};
    logic [31:0] model [2][c_DEPTH0];
    txn_t        pend[$];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(c_DEPTH0), .WAIT_CYCLES(c_WAIT0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_we(rwe[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]), .req_ready(qrdy[0]),
        .rsp_valid(qval[0]), .rsp_ready(rr[0]), .rsp_rdata(qdat[0]), .rsp_err(qerr[0])
    );

    mem_responder #(.DEPTH_WORDS(c_DEPTH1), .WAIT_CYCLES(c_WAIT1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_we(rwe[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]), .req_ready(qrdy[1]),
        .rsp_valid(qval[1]), .rsp_ready(rr[1]), .rsp_rdata(qdat[1]), .rsp_err(qerr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void clear_model();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < c_DEPTH0; i++)
                model[w][i] = 32'd0;
    endfunction

    // Reference behaviour: word-addressed store, errors leave it untouched.
    function automatic void model_txn(input int w, input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata,
                                      output logic err, output logic [31:0] rdata);
        longint unsigned word;
        word  = longint'(addr) / 4;
        err   = ((addr % 4) != 0) || (word >= longint'(depth[w]));
        rdata = 32'd0;
        if (!err) begin
            if (we) model[w][word] = wdata;
            else    rdata = model[w][word];
        end
    endfunction

    task automatic idle_inputs();
        for (int w = 0; w < 2; w++) begin
            rv[w] = 1'b0; rwe[w] = 1'b0; rr[w] = 1'b0; ra[w] = '0; rwd[w] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic check_idle(input int w, input string tag);
        chk({tag, "_ready"}, 32'(qrdy[w]), 32'd1);
        chk({tag, "_valid"}, 32'(qval[w]), 32'd0);
        chk({tag, "_err"},   32'(qerr[w]), 32'd0);
        chk({tag, "_rdata"}, qdat[w], 32'd0);
    endtask

    task automatic txn(input int w, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
        logic        exp_err;
        logic [31:0] exp_dat;
        int          n;
        @(negedge clk);
        chk("req_ready_idle", 32'(qrdy[w]), 32'd1);
        rv[w] = 1'b1; rwe[w] = we; ra[w] = addr; rwd[w] = wdata;
        @(posedge clk); #1;
        model_txn(w, we, addr, wdata, exp_err, exp_dat);
        // Scramble request inputs after accept; the responder must use the latched copy.
        rv[w] = 1'b0; rwe[w] = ~we; ra[w] = $urandom; rwd[w] = $urandom;
        n = 0;
        while (!qval[w] && n < 40) begin
            chk("req_ready_wait", 32'(qrdy[w]), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_latency", 32'(n), 32'(waitc[w]));
        chk("rsp_err", 32'(qerr[w]), 32'(exp_err));
        chk("rsp_rdata", qdat[w], exp_dat);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(qval[w]), 32'd1);
            chk("hold_ready", 32'(qrdy[w]), 32'd0);
            chk("hold_err",   32'(qerr[w]), 32'(exp_err));
            chk("hold_rdata", qdat[w], exp_dat);
        end
        @(negedge clk);
        rr[w] = 1'b1;
        rv[w] = 1'b1;   // must not be accepted on the completing edge
        @(posedge clk); #1;
        rr[w] = 1'b0;
        rv[w] = 1'b0;
        check_idle(w, "after_rsp");
    endtask

    task automatic rand_txn(input int w);
        logic [31:0] addr;
        addr = 32'($urandom_range(0, depth[w] + 8)) * 4;
        if ($urandom_range(0, 5) == 0) addr = addr + 32'($urandom_range(1, 3));
        txn(w, 1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 2));
    endtask

    // Back-to-back requests with req_valid held high and rsp_ready held high.
    task automatic stream_test();
        int          period;
        logic        exp_err;
        logic [31:0] exp_dat;
        txn_t        t;
        period = c_WAIT0 + 2;
        pend.delete();
        rr[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rv[0]  = 1'b1;
            rwe[0] = 1'($urandom_range(0, 1));
            rwd[0] = $urandom;
            ra[0]  = 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 7) == 0) ra[0] = ra[0] + 32'd1;
            chk("stream_ready", 32'(qrdy[0]), 32'((c % period) == 0));
            if ((c % period) == 0) pend.push_back('{rwe[0], ra[0], rwd[0]});
            @(posedge clk); #1;
            chk("stream_valid", 32'(qval[0]), 32'((c % period) == c_WAIT0));
            if ((c % period) == c_WAIT0 && pend.size() > 0) begin
                t = pend.pop_front();
                model_txn(0, t.we, t.addr, t.wdata, exp_err, exp_dat);
                chk("stream_err", 32'(qerr[0]), 32'(exp_err));
                chk("stream_rdata", qdat[0], exp_dat);
            end
        end
        @(negedge clk);
        rv[0] = 1'b0;
        rr[0] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        clear_model();
        do_reset();
        check_idle(0, "reset0");
        check_idle(1, "reset1");

        // Write then read back the same word.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);

        // Misaligned read, out-of-range write, then word 0 is still clear.
        txn(0, 1'b0, 32'h13, 32'h0, 0);
        txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 0);
        txn(0, 1'b1, 32'h3FC, 32'h0BADF00D, 0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 0);

        // Back-pressure: response held for five cycles.
        txn(0, 1'b0, 32'h10, 32'h0, 5);

        // Zero-wait-state instance.
        txn(1, 1'b1, 32'h10, 32'hA5A5_5A5A, 0);
        txn(1, 1'b0, 32'h10, 32'h0, 0);
        txn(1, 1'b0, 32'h40, 32'h0, 1);
        txn(1, 1'b1, 32'h3E, 32'h1111_2222, 0);

        for (int i = 0; i < 20; i++) rand_txn(0);
        for (int i = 0; i < 8; i++)  rand_txn(1);

        stream_test();

        // Reset in the middle of a pending write.
        @(negedge clk);
        rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'h12345678;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        chk("abort_in_wait", 32'(qval[0]), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_idle(0, "abort_reset");
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        txn(0, 1'b0, 32'h20, 32'h0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
